// File: rtl/isqrt_pipe_with_valid.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_pipe_with_valid
//  Description : Fully pipelined unsigned integer square root. Accepts one
//                radicand per clock and returns floor(sqrt(in_data)) exactly
//                `latency` (= width/2) cycles later, qualified by out_vld.
//                One result bit is resolved per stage using the restoring
//                digit-by-digit method. There is no stall and no backpressure.
//  Ports       : clk      - clock, rising edge
//                rst      - synchronous active-high reset (clears all stages)
//                in_vld   - in_data is a valid transfer this cycle
//                in_data  - unsigned radicand, width bits
//                out_vld  - out_data / out_rem carry a valid result
//                out_data - floor(sqrt(radicand)), width/2 bits
//                out_rem  - radicand - out_data^2, width/2+1 bits
//                           (only when ISQRT_REMAINDER_EN is defined)
//  Config      : ISQRT_REMAINDER_EN - adds the out_rem port
//  Revision    : 1.0 - initial release
// ============================================================================
module isqrt_pipe_with_valid #(
    parameter int width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [width-1:0]     in_data,
    output logic                 out_vld,
`ifdef ISQRT_REMAINDER_EN
    output logic [width/2:0]     out_rem,
`endif
    output logic [width/2-1:0]   out_data
);

    localparam int latency = width / 2;
    localparam int c_h     = width / 2;      // root width
    localparam int c_rw    = width / 2 + 2;  // partial remainder width

    // Per-stage output registers, indexed by stage number.
    logic [width-1:0] r_x [latency];
    logic [c_rw-1:0]  r_r [latency];
    logic [c_h-1:0]   r_q [latency];
    logic             r_v [latency];

    for (genvar s = 0; s < latency; s++) begin : g_stage
        logic [width-1:0] w_px;
        logic [c_rw-1:0]  w_pr;
        logic [c_h-1:0]   w_pq;
        logic             w_pv;
        logic [c_rw-1:0]  w_rs;
        logic [c_rw-1:0]  w_t;
        logic             w_ge;

        if (s == 0) begin : g_first
            assign w_px = in_data;
            assign w_pr = '0;
            assign w_pq = '0;
            assign w_pv = in_vld;
        end else begin : g_next
            assign w_px = r_x[s-1];
            assign w_pr = r_r[s-1];
            assign w_pq = r_q[s-1];
            assign w_pv = r_v[s-1];
        end

        // Bring down the next two radicand bits. The top two bits of the
        // previous remainder are always zero (remainder <= 2q), so dropping
        // them in the shift loses nothing.
        assign w_rs = {w_pr[c_rw-3:0], w_px[width-1:width-2]};
        // Trial subtrahend 4q+1; exactly c_rw bits wide, no extension needed.
        assign w_t  = {w_pq, 2'b01};
        assign w_ge = (w_rs >= w_t);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_x[s] <= '0;
                r_r[s] <= '0;
                r_q[s] <= '0;
                r_v[s] <= 1'b0;
            end else begin
                r_x[s] <= {w_px[width-3:0], 2'b00};
                r_r[s] <= w_ge ? (w_rs - w_t) : w_rs;
                // q's top bit is always zero before the last stage, so the
                // left shift never discards a set bit.
                r_q[s] <= {w_pq[c_h-2:0], w_ge};
                r_v[s] <= w_pv;
            end
        end
    end

    assign out_vld  = r_v[latency-1];
    assign out_data = r_q[latency-1];
`ifdef ISQRT_REMAINDER_EN
    assign out_rem  = r_r[latency-1][c_h:0];
`endif

endmodule
`default_nettype wire
